// File: rtl/arcade_input_conditioner.sv
//------------------------------------------------------------------------------
// Module   : arcade_input_conditioner
// Purpose  : Conditions the two hps_io joystick words for the galaga core in the
//            clk_sys domain. The pads are merged and opposing directions are
//            suppressed. Start lines are produced, each coin press becomes a
//            fixed-width pulse followed by a guard window, and the pause button
//            toggles a latched pause request.
// Macro    : AUTOFIRE_EN - when defined, adds an autofire generator on the fire
//            button, gated by autofire_en. When undefined, m_fire is raw fire.
// Ports    : clk_sys            system clock, rising edge
//            reset_n            asynchronous active-low reset
//            joystick_0/1[15:0] pads: [0]R [1]L [2]D [3]U [4]fire [5]start1P
//                               [6]start2P [7]coin [8]pause
//            autofire_en        autofire enable (AUTOFIRE_EN builds only)
//            pause_clr          synchronous clear of pause_req
//            m_up/down/left/right, m_fire, m_start1, m_start2  level outputs
//            m_coin1, m_coin2   shaped coin pulses
//            pause_req          toggled pause request
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module arcade_input_conditioner #(
   parameter int CLK_KHZ = 18432,
   parameter int COIN_MS = 50,
   parameter int AF_MS   = 33
) (
   input  logic        clk_sys,
   input  logic        reset_n,
   input  logic [15:0] joystick_0,
   input  logic [15:0] joystick_1,
   input  logic        autofire_en,
   input  logic        pause_clr,
   output logic        m_up,
   output logic        m_down,
   output logic        m_left,
   output logic        m_right,
   output logic        m_fire,
   output logic        m_start1,
   output logic        m_start2,
   output logic        m_coin1,
   output logic        m_coin2,
   output logic        pause_req
);

   localparam int COIN_CYC = COIN_MS * CLK_KHZ;
   localparam int CW       = (COIN_CYC > 1) ? $clog2(COIN_CYC) : 1;
   localparam logic [CW-1:0] COIN_LOAD = CW'(COIN_CYC - 1);

   typedef enum logic [1:0] {
      COIN_IDLE  = 2'd0,
      COIN_PULSE = 2'd1,
      COIN_GUARD = 2'd2
   } coin_state_e;

   // Only the mapped bits of each pad are registered.
   logic [8:0] j0_q, j1_q;
   logic [8:0] joy;
   logic [1:0] coin_prev_q;
   logic       pause_prev_q;
   logic       up_q, down_q, left_q, right_q, fire_q, start1_q, start2_q;
   logic       pause_q, pause_d;
   logic       fire_d;
   logic [1:0] coin_raw;
   logic [1:0] coin_out;
   logic       unused_bits;

   assign joy      = j0_q | j1_q;
   assign coin_raw = {j1_q[7], j0_q[7]};

   // Input stage, edge-detect history and registered level outputs.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         j0_q         <= '0;
         j1_q         <= '0;
         coin_prev_q  <= '0;
         pause_prev_q <= 1'b0;
         up_q         <= 1'b0;
         down_q       <= 1'b0;
         left_q       <= 1'b0;
         right_q      <= 1'b0;
         fire_q       <= 1'b0;
         start1_q     <= 1'b0;
         start2_q     <= 1'b0;
         pause_q      <= 1'b0;
      end else begin
         j0_q         <= joystick_0[8:0];
         j1_q         <= joystick_1[8:0];
         coin_prev_q  <= coin_raw;
         pause_prev_q <= joy[8];
         // Opposing directions cancel each other out.
         up_q         <= joy[3] & ~joy[2];
         down_q       <= joy[2] & ~joy[3];
         left_q       <= joy[1] & ~joy[0];
         right_q      <= joy[0] & ~joy[1];
         fire_q       <= fire_d;
         // Each start line combines one pad's own start with the other
         // pad's cross start.
         start1_q     <= j0_q[5] | j1_q[6];
         start2_q     <= j1_q[5] | j0_q[6];
         pause_q      <= pause_d;
      end
   end

   // The clear has priority over a same-cycle toggle edge.
   always_comb begin
      pause_d = pause_q ^ (joy[8] & ~pause_prev_q);
      if (pause_clr) begin
         pause_d = 1'b0;
      end
   end

   // Coin shapers: one pulse of COIN_CYC clocks, then a guard window of the
   // same length in which further edges are ignored.
   for (genvar gi = 0; gi < 2; gi++) begin : g_coin
      coin_state_e    state_q, state_d;
      logic [CW-1:0]  cnt_q, cnt_d;
      logic           rise;

      assign rise = coin_raw[gi] & ~coin_prev_q[gi];

      always_ff @(posedge clk_sys or negedge reset_n) begin
         if (!reset_n) begin
            state_q <= COIN_IDLE;
            cnt_q   <= '0;
         end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
         end
      end

      always_comb begin
         state_d = state_q;
         cnt_d   = cnt_q;
         case (state_q)
            COIN_IDLE: begin
               if (rise) begin
                  state_d = COIN_PULSE;
                  cnt_d   = COIN_LOAD;
               end
            end
            COIN_PULSE: begin
               if (cnt_q == '0) begin
                  state_d = COIN_GUARD;
                  cnt_d   = COIN_LOAD;
               end else begin
                  cnt_d = cnt_q - CW'(1);
               end
            end
            COIN_GUARD: begin
               if (cnt_q == '0) begin
                  state_d = COIN_IDLE;
               end else begin
                  cnt_d = cnt_q - CW'(1);
               end
            end
            default: begin
               state_d = COIN_IDLE;
               cnt_d   = '0;
            end
         endcase
      end

      assign coin_out[gi] = (state_q == COIN_PULSE);
   end

`ifdef AUTOFIRE_EN
   localparam int AF_CYC = AF_MS * CLK_KHZ;
   localparam int AW     = (AF_CYC > 1) ? $clog2(AF_CYC) : 1;
   localparam logic [AW-1:0] AF_LAST = AW'(AF_CYC - 1);

   logic [AW-1:0] af_cnt_q, af_cnt_d;
   logic          af_low_q, af_low_d;

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         af_cnt_q <= '0;
         af_low_q <= 1'b0;
      end else begin
         af_cnt_q <= af_cnt_d;
         af_low_q <= af_low_d;
      end
   end

   // af_low_q marks the low half of the period. Both the counter and the
   // phase clear whenever fire is not being autofired, so every new press
   // starts with a full high half-period.
   always_comb begin
      af_cnt_d = '0;
      af_low_d = 1'b0;
      fire_d   = joy[4];
      if (autofire_en && joy[4]) begin
         fire_d = ~af_low_q;
         if (af_cnt_q == AF_LAST) begin
            af_low_d = ~af_low_q;
         end else begin
            af_cnt_d = af_cnt_q + AW'(1);
            af_low_d = af_low_q;
         end
      end
   end

   assign unused_bits = ^{joystick_0[15:9], joystick_1[15:9], joy[7:5]};
`else
   assign fire_d      = joy[4];
   assign unused_bits = ^{joystick_0[15:9], joystick_1[15:9], joy[7:5], autofire_en};
`endif

   assign m_up      = up_q;
   assign m_down    = down_q;
   assign m_left    = left_q;
   assign m_right   = right_q;
   assign m_fire    = fire_q;
   assign m_start1  = start1_q;
   assign m_start2  = start2_q;
   assign m_coin1   = coin_out[0];
   assign m_coin2   = coin_out[1];
   assign pause_req = pause_q;

endmodule

`default_nettype wire
